// File: rtl/axi3_mem_responder.sv
// AXI3 burst slave backed by a local 64-bit flop-array memory.
// One outstanding burst at a time; read and write address channels share a round-robin grant.
module axi3_mem_responder #(
    parameter int unsigned                  addr_width_p = 32,
    parameter int unsigned                  id_width_p   = 6,
    parameter int unsigned                  mem_els_lg_p = 10,
    parameter logic [addr_width_p-1:0]      base_addr_p  = 'h8000_0000
) (
    input  logic                    aclk,
    input  logic                    aresetn,

    input  logic [addr_width_p-1:0] s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [id_width_p-1:0]   s_axi_awid,
    input  logic [3:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,

    input  logic [63:0]             s_axi_wdata,
    input  logic [7:0]              s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    input  logic                    s_axi_wlast,

    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    output logic [id_width_p-1:0]   s_axi_bid,
    output logic [1:0]              s_axi_bresp,

    input  logic [addr_width_p-1:0] s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    input  logic [id_width_p-1:0]   s_axi_arid,
    input  logic [3:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,

    output logic [63:0]             s_axi_rdata,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [id_width_p-1:0]   s_axi_rid,
    output logic                    s_axi_rlast,
    output logic [1:0]              s_axi_rresp
);

    localparam int unsigned              Depth  = 1 << mem_els_lg_p;
    localparam logic [mem_els_lg_p-1:0]  IdxOne = 1;
    localparam logic [4:0]               CntOne = 5'd1;

    typedef enum logic [1:0] {
        IDLE,
        WDATA,
        WRESP,
        RDATA
    } state_e;

    state_e                  r_state;
    logic                    r_prio_w;
    logic [id_width_p-1:0]   r_id;
    logic [mem_els_lg_p-1:0] r_idx;
    logic [4:0]              r_cnt;
    logic                    r_err;
    logic [63:0]             r_mem [0:Depth-1];

    logic                    w_aw_go;
    logic                    w_ar_go;
    logic                    w_w_go;
    logic                    w_r_go;
    logic                    w_last_beat;

    // Offset from base is checked on its upper bits so the window end never overflows.
    function automatic logic addr_err(input logic [addr_width_p-1:0] a, input logic [2:0] size);
        logic [addr_width_p-1:0] off;
        off = a - base_addr_p;
        return (size != 3'd3) || (a < base_addr_p) || ((off >> (mem_els_lg_p + 3)) != '0);
    endfunction

    function automatic logic [mem_els_lg_p-1:0] word_idx(input logic [addr_width_p-1:0] a);
        logic [addr_width_p-1:0] off;
        off = a - base_addr_p;
        return off[mem_els_lg_p+2:3];
    endfunction

    assign s_axi_awready = (r_state == IDLE) && s_axi_awvalid && (!s_axi_arvalid || r_prio_w);
    assign s_axi_arready = (r_state == IDLE) && s_axi_arvalid && (!s_axi_awvalid || !r_prio_w);
    assign w_aw_go       = s_axi_awready;
    assign w_ar_go       = s_axi_arready;

    assign s_axi_wready  = (r_state == WDATA);
    assign s_axi_bvalid  = (r_state == WRESP);
    assign s_axi_rvalid  = (r_state == RDATA);
    assign w_w_go        = s_axi_wready && s_axi_wvalid;
    assign w_r_go        = s_axi_rvalid && s_axi_rready;
    assign w_last_beat   = (r_cnt == CntOne);

    assign s_axi_bid     = r_id;
    assign s_axi_rid     = r_id;
    assign s_axi_bresp   = {(r_state == WRESP) && r_err, 1'b0};
    assign s_axi_rresp   = {(r_state == RDATA) && r_err, 1'b0};
    assign s_axi_rlast   = (r_state == RDATA) && w_last_beat;
    assign s_axi_rdata   = ((r_state == RDATA) && !r_err) ? r_mem[r_idx] : '0;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state  <= IDLE;
            r_prio_w <= 1'b1;
            r_id     <= '0;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_aw_go) begin
                        r_state  <= WDATA;
                        r_prio_w <= 1'b0;
                        r_id     <= s_axi_awid;
                        r_idx    <= word_idx(s_axi_awaddr);
                        r_cnt    <= {1'b0, s_axi_awlen} + CntOne;
                        r_err    <= addr_err(s_axi_awaddr, s_axi_awsize);
                    end else if (w_ar_go) begin
                        r_state  <= RDATA;
                        r_prio_w <= 1'b1;
                        r_id     <= s_axi_arid;
                        r_idx    <= word_idx(s_axi_araddr);
                        r_cnt    <= {1'b0, s_axi_arlen} + CntOne;
                        r_err    <= addr_err(s_axi_araddr, s_axi_arsize);
                    end
                end
                WDATA: begin
                    if (w_w_go) begin
                        r_idx <= r_idx + IdxOne;
                        r_cnt <= r_cnt - CntOne;
                        if (s_axi_wlast != w_last_beat) begin
                            r_err <= 1'b1;
                        end
                        if (w_last_beat) begin
                            r_state <= WRESP;
                        end
                    end
                end
                WRESP: begin
                    if (s_axi_bready) begin
                        r_state <= IDLE;
                    end
                end
                RDATA: begin
                    if (w_r_go) begin
                        r_idx <= r_idx + IdxOne;
                        r_cnt <= r_cnt - CntOne;
                        if (w_last_beat) begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Memory is deliberately left out of reset so accepted writes survive an abort.
    always_ff @(posedge aclk) begin
        if (w_w_go && !r_err) begin
            for (int unsigned b = 0; b < 8; b++) begin
                if (s_axi_wstrb[b]) begin
                    r_mem[r_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_axi3_mem_responder.sv
// Randomized bench for axi3_mem_responder against a word-array model of the memory window.
module tb_axi3_mem_responder;

    localparam int unsigned AW    = 32;
    localparam int unsigned IW    = 6;
    localparam int unsigned LG    = 10;
    localparam int unsigned DEPTH = 1 << LG;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [AW-1:0] s_axi_awaddr;
    logic          s_axi_awvalid;
    logic          s_axi_awready;
    logic [IW-1:0] s_axi_awid;
    logic [3:0]    s_axi_awlen;
    logic [2:0]    s_axi_awsize;
    logic [63:0]   s_axi_wdata;
    logic [7:0]    s_axi_wstrb;
    logic          s_axi_wvalid;
    logic          s_axi_wready;
    logic          s_axi_wlast;
    logic          s_axi_bvalid;
    logic          s_axi_bready;
    logic [IW-1:0] s_axi_bid;
    logic [1:0]    s_axi_bresp;
    logic [AW-1:0] s_axi_araddr;
    logic          s_axi_arvalid;
    logic          s_axi_arready;
    logic [IW-1:0] s_axi_arid;
    logic [3:0]    s_axi_arlen;
    logic [2:0]    s_axi_arsize;
    logic [63:0]   s_axi_rdata;
    logic          s_axi_rvalid;
    logic          s_axi_rready;
    logic [IW-1:0] s_axi_rid;
    logic          s_axi_rlast;
    logic [1:0]    s_axi_rresp;

    axi3_mem_responder #(
        .addr_width_p (AW),
        .id_width_p   (IW),
        .mem_els_lg_p (LG),
        .base_addr_p  (BASE)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_awid    (s_axi_awid),
        .s_axi_awlen   (s_axi_awlen),
        .s_axi_awsize  (s_axi_awsize),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_wlast   (s_axi_wlast),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_bid     (s_axi_bid),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_arid    (s_axi_arid),
        .s_axi_arlen   (s_axi_arlen),
        .s_axi_arsize  (s_axi_arsize),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .s_axi_rid     (s_axi_rid),
        .s_axi_rlast   (s_axi_rlast),
        .s_axi_rresp   (s_axi_rresp)
    );

    always #5 aclk = ~aclk;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;
    logic [63:0] mem_m [DEPTH];
    logic [63:0] tb_wd [16];
    logic [7:0]  tb_ws [16];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    function automatic bit win_err(input logic [31:0] a, input logic [2:0] size);
        longint unsigned x;
        x = a;
        return (size != 3'd3) || (x < BASE) || (x >= longint'(BASE) + 8 * DEPTH);
    endfunction

    function automatic int unsigned word_of(input logic [31:0] a);
        logic [31:0] d;
        d = a - BASE;
        return (d / 8) % DEPTH;
    endfunction

    function automatic logic [31:0] rand_addr(input int unsigned kind);
        if (kind == 1) return BASE - 8 * $urandom_range(1, 4);
        if (kind == 2) return BASE + 8 * DEPTH + 8 * $urandom_range(0, 4);
        return BASE + 8 * $urandom_range(0, DEPTH - 1);
    endfunction

    // bad_beat >= 0 asserts wlast on that beat only; -1 marks the true final beat.
    task automatic axi_write(input logic [31:0] addr, input logic [IW-1:0] id, input logic [3:0] len,
                             input logic [2:0] size, input int bad_beat, input int unsigned b_delay);
        bit          err;
        int unsigned idx;
        int unsigned n;
        logic [63:0] w;
        err = win_err(addr, size);
        idx = word_of(addr);
        s_axi_awaddr = addr; s_axi_awid = id; s_axi_awlen = len; s_axi_awsize = size;
        s_axi_awvalid = 1'b1;
        #1;
        n = 0;
        while (!s_axi_awready && n < 20) begin step(); #1; n++; end
        if (n >= 20) begin
            check_eq("aw_timeout", 0, 1);
            s_axi_awvalid = 1'b0;
            return;
        end
        step();
        s_axi_awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            s_axi_wdata  = tb_wd[b];
            s_axi_wstrb  = tb_ws[b];
            s_axi_wlast  = (bad_beat >= 0) ? (b == bad_beat) : (b == int'(len));
            s_axi_wvalid = 1'b1;
            #1;
            check_eq("wready", s_axi_wready, 1);
            if (!err) begin
                w = mem_m[(idx + b) % DEPTH];
                for (int k = 0; k < 8; k++)
                    if (tb_ws[b][k]) w[8*k +: 8] = tb_wd[b][8*k +: 8];
                mem_m[(idx + b) % DEPTH] = w;
            end
            if (s_axi_wlast != (b == int'(len))) err = 1'b1;
            step();
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
        #1;
        check_eq("bvalid_rise", s_axi_bvalid, 1);
        for (int unsigned d = 0; d < b_delay; d++) begin
            step(); #1;
            check_eq("bvalid_hold", s_axi_bvalid, 1);
        end
        s_axi_bready = 1'b1;
        #1;
        check_eq("bid", s_axi_bid, id);
        check_eq("bresp", s_axi_bresp, err ? 2'b10 : 2'b00);
        step();
        s_axi_bready = 1'b0;
        #1;
        check_eq("bvalid_fall", s_axi_bvalid, 0);
    endtask

    // rmode: 0 always ready, 1 toggling starting low, 2 random.
    task automatic axi_read(input logic [31:0] addr, input logic [IW-1:0] id, input logic [3:0] len,
                            input logic [2:0] size, input int unsigned rmode);
        bit          err;
        int unsigned idx;
        int unsigned n;
        int          b;
        bit          ph;
        err = win_err(addr, size);
        idx = word_of(addr);
        s_axi_araddr = addr; s_axi_arid = id; s_axi_arlen = len; s_axi_arsize = size;
        s_axi_arvalid = 1'b1;
        #1;
        n = 0;
        while (!s_axi_arready && n < 20) begin step(); #1; n++; end
        if (n >= 20) begin
            check_eq("ar_timeout", 0, 1);
            s_axi_arvalid = 1'b0;
            return;
        end
        step();
        s_axi_arvalid = 1'b0;
        b = 0; n = 0; ph = 1'b0;
        while (b <= int'(len) && n < 200) begin
            s_axi_rready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ph : 1'($urandom_range(0, 1));
            ph = !ph;
            #1;
            check_eq("rvalid", s_axi_rvalid, 1);
            check_eq("rdata", s_axi_rdata, err ? 64'd0 : mem_m[(idx + b) % DEPTH]);
            check_eq("rlast", s_axi_rlast, b == int'(len));
            check_eq("rresp", s_axi_rresp, err ? 2'b10 : 2'b00);
            check_eq("rid", s_axi_rid, id);
            if (s_axi_rready) b++;
            step();
            n++;
        end
        s_axi_rready = 1'b0;
        if (n >= 200) check_eq("r_timeout", 0, 1);
        #1;
        check_eq("rvalid_fall", s_axi_rvalid, 0);
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  len;
        logic [2:0]  size;
        int          bad;
        int unsigned kind;
        int unsigned n;
        bit          g;

        aresetn = 1'b0;
        s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_awid = '0; s_axi_awlen = '0; s_axi_awsize = '0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_bready = 1'b0;
        s_axi_araddr = '0; s_axi_arvalid = 1'b0; s_axi_arid = '0; s_axi_arlen = '0; s_axi_arsize = '0;
        s_axi_rready = 1'b0;
        #3;
        check_eq("rst_awready", s_axi_awready, 0);
        check_eq("rst_arready", s_axi_arready, 0);
        check_eq("rst_wready", s_axi_wready, 0);
        check_eq("rst_bvalid", s_axi_bvalid, 0);
        check_eq("rst_rvalid", s_axi_rvalid, 0);
        check_eq("rst_rlast", s_axi_rlast, 0);
        check_eq("rst_resp", {s_axi_bresp, s_axi_rresp}, 0);
        check_eq("rst_ids", {s_axi_bid, s_axi_rid}, 0);
        check_eq("rst_rdata", s_axi_rdata, 0);
        step(); step();
        aresetn = 1'b1;
        step();

        // Fill the whole window so the model and the array start identical.
        for (int unsigned blk = 0; blk < DEPTH / 16; blk++) begin
            for (int b = 0; b < 16; b++) begin
                tb_wd[b] = {$urandom, $urandom};
                tb_ws[b] = 8'hFF;
                mem_m[blk * 16 + b] = 'x;
            end
            axi_write(BASE + 32'(blk * 128), 6'(blk), 4'd15, 3'd3, -1, 0);
        end

        for (int b = 0; b < 4; b++) begin tb_wd[b] = 64'(8'h11 * (b + 1)); tb_ws[b] = 8'hFF; end
        axi_write(BASE + 32'h10, 6'h2A, 4'd3, 3'd3, -1, 1);
        axi_read(BASE + 32'h10, 6'h15, 4'd3, 3'd3, 1);

        tb_wd[0] = '1; tb_ws[0] = 8'hFF;
        axi_write(BASE + 32'h40, 6'h01, 4'd0, 3'd3, -1, 0);
        tb_wd[0] = '0; tb_ws[0] = 8'h0F;
        axi_write(BASE + 32'h40, 6'h02, 4'd0, 3'd3, -1, 0);
        axi_read(BASE + 32'h40, 6'h03, 4'd0, 3'd3, 0);
        check_eq("partial_strobe", mem_m[8], 64'hFFFF_FFFF_0000_0000);

        axi_read(BASE - 32'd8, 6'h04, 4'd2, 3'd3, 0);
        for (int b = 0; b < 4; b++) begin tb_wd[b] = {$urandom, $urandom}; tb_ws[b] = 8'hFF; end
        axi_write(BASE + 32'h80, 6'h05, 4'd1, 3'd2, -1, 0);
        axi_read(BASE + 32'h80, 6'h06, 4'd1, 3'd3, 0);
        axi_write(BASE + 32'h100, 6'h07, 4'd3, 3'd3, 1, 0);
        axi_read(BASE + 32'h100, 6'h08, 4'd3, 3'd3, 2);

        for (int b = 0; b < 2; b++) begin tb_wd[b] = {$urandom, $urandom}; tb_ws[b] = 8'hFF; end
        axi_write(BASE + 32'(8 * (DEPTH - 1)), 6'h09, 4'd1, 3'd3, -1, 0);
        axi_read(BASE, 6'h0A, 4'd0, 3'd3, 0);
        axi_read(BASE + 32'(8 * (DEPTH - 1)), 6'h0B, 4'd1, 3'd3, 0);

        // Abort a read burst with reset after two beats.
        s_axi_araddr = BASE; s_axi_arid = 6'h0C; s_axi_arlen = 4'd7; s_axi_arsize = 3'd3;
        s_axi_arvalid = 1'b1;
        #1;
        n = 0;
        while (!s_axi_arready && n < 20) begin step(); #1; n++; end
        check_eq("mid_rst_ar", n < 20, 1);
        step();
        s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b1;
        step(); step();
        #1;
        check_eq("mid_rst_busy", s_axi_rvalid, 1);
        aresetn = 1'b0;
        #1;
        check_eq("mid_rst_rvalid", s_axi_rvalid, 0);
        check_eq("mid_rst_rlast", s_axi_rlast, 0);
        check_eq("mid_rst_rdata", s_axi_rdata, 0);
        s_axi_rready = 1'b0;
        step(); step();
        aresetn = 1'b1;
        step(); #1;
        check_eq("post_rst_rvalid", s_axi_rvalid, 0);
        check_eq("post_rst_wready", s_axi_wready, 0);

        // Both address channels held valid: grants alternate starting with write.
        s_axi_awaddr = BASE + 32'h28; s_axi_awid = 6'h11; s_axi_awlen = 4'd0; s_axi_awsize = 3'd3;
        s_axi_araddr = BASE + 32'h30; s_axi_arid = 6'h22; s_axi_arlen = 4'd0; s_axi_arsize = 3'd3;
        s_axi_awvalid = 1'b1; s_axi_arvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n = 0;
            while (!(s_axi_awready || s_axi_arready) && n < 20) begin step(); #1; n++; end
            check_eq("arb_timeout", n < 20, 1);
            g = s_axi_awready;
            check_eq("arb_excl", s_axi_awready && s_axi_arready, 0);
            check_eq("arb_order", g, (k % 2) == 0);
            step();
            if (k == 3) begin s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0; end
            if (g) begin
                s_axi_wdata = {$urandom, $urandom}; s_axi_wstrb = 8'hFF; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
                #1;
                check_eq("arb_wready", s_axi_wready, 1);
                mem_m[5] = s_axi_wdata;
                step();
                s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_bready = 1'b1;
                #1;
                check_eq("arb_bvalid", s_axi_bvalid, 1);
                check_eq("arb_bid", s_axi_bid, 6'h11);
                step();
                s_axi_bready = 1'b0;
            end else begin
                s_axi_rready = 1'b1;
                #1;
                check_eq("arb_rvalid", s_axi_rvalid, 1);
                check_eq("arb_rdata", s_axi_rdata, mem_m[6]);
                check_eq("arb_rid", s_axi_rid, 6'h22);
                step();
                s_axi_rready = 1'b0;
            end
        end
        axi_read(BASE + 32'h28, 6'h0D, 4'd0, 3'd3, 0);

        for (int t = 0; t < 80; t++) begin
            kind = $urandom_range(0, 9);
            a    = rand_addr(kind <= 2 ? kind : 0);
            len  = 4'($urandom_range(0, 15));
            size = ($urandom_range(0, 9) == 0) ? 3'd2 : 3'd3;
            if ($urandom_range(0, 1) == 1) begin
                for (int b = 0; b < 16; b++) begin
                    tb_wd[b] = {$urandom, $urandom};
                    tb_ws[b] = 8'($urandom);
                end
                bad = ($urandom_range(0, 7) == 0 && len > 0) ? int'($urandom_range(0, int'(len) - 1)) : -1;
                axi_write(a, 6'($urandom), len, size, bad, $urandom_range(0, 2));
            end else begin
                axi_read(a, 6'($urandom), len, size, $urandom_range(0, 2));
            end
        end

        for (int unsigned blk = 0; blk < DEPTH / 16; blk++)
            axi_read(BASE + 32'(blk * 128), 6'(blk), 4'd15, 3'd3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/axi3_mem_responder.md
# axi3_mem_responder
AXI3 burst slave that answers the PL-side 64-bit memory master port (m00_axi) from a local flop-array memory, so cosim and bring-up builds can run without the PS DDR path. It accepts one read or write burst at a time, with round-robin arbitration between the read and write channels. It returns OKAY or SLVERR responses with the request ID echoed.
## Interface
- addr_width_p, 32, byte address width of awaddr/araddr
- id_width_p, 6, width of all ID fields
- mem_els_lg_p, 10, log2 of memory depth in 64-bit words
- base_addr_p, 32'h8000_0000, byte address of word 0; the window is [base, base + 8·2^mem_els_lg_p)
- aclk  in  1  sole clock, rising edge
- aresetn  in  1  asynchronous active-low reset
- s_axi_awaddr  in  addr_width_p  burst start byte address
- s_axi_awvalid  in  1  write address valid
- s_axi_awready  out  1  write address accept
- s_axi_awid  in  id_width_p  write ID
- s_axi_awlen  in  4  beats minus one (AXI3)
- s_axi_awsize  in  3  must be 3 (8 bytes)
- s_axi_wdata  in  64  write beat data
- s_axi_wstrb  in  8  byte enables
- s_axi_wvalid  in  1  write beat valid
- s_axi_wready  out  1  write beat accept
- s_axi_wlast  in  1  final write beat marker
- s_axi_bvalid  out  1  write response valid
- s_axi_bready  in  1  write response accept
- s_axi_bid  out  id_width_p  echoed awid
- s_axi_bresp  out  2  00 OKAY, 10 SLVERR
- s_axi_araddr  in  addr_width_p  burst start byte address
- s_axi_arvalid  in  1  read address valid
- s_axi_arready  out  1  read address accept
- s_axi_arid  in  id_width_p  read ID
- s_axi_arlen  in  4  beats minus one
- s_axi_arsize  in  3  must be 3
- s_axi_rdata  out  64  read beat data
- s_axi_rvalid  out  1  read beat valid
- s_axi_rready  in  1  read beat accept
- s_axi_rid  out  id_width_p  echoed arid
- s_axi_rlast  out  1  final read beat marker
- s_axi_rresp  out  2  00 OKAY, 10 SLVERR
## Operation
- States: IDLE, WDATA, WRESP, RDATA. There is exactly one outstanding transaction. All bursts are treated as INCR; wid, lock, cache, prot and qos are not ports.
- IDLE arbitration:
  - awready = awvalid & (~arvalid | prio_w).
  - arready = arvalid & (~awvalid | ~prio_w).
  - prio_w resets to 1 and flips to the opposite channel after every grant.
- On an AW handshake: latch the ID, the word index ((addr − base) >> 3, with the low mem_els_lg_p bits kept), beat count len+1, and err. Then go to WDATA.
- err is set when size ≠ 3, addr < base, or addr ≥ base + 8·2^mem_els_lg_p. Only the start address is checked; the word index wraps modulo depth within a burst.
- WDATA:
  - wready = 1.
  - Each accepted beat writes the bytes enabled by wstrb unless err is set, then increments the index.
  - If wlast ≠ (this is the final beat), err is set; the write of that beat still occurs.
  - After beat len+1 the block goes to WRESP. The beat count alone ends the burst.
- WRESP: bvalid = 1, bid = latched ID, bresp = err ? 10 : 00. On bready it returns to IDLE.
- On an AR handshake: latch the same fields, then go to RDATA.
- RDATA:
  - rvalid = 1, rdata = mem[index] (asynchronous array read), or 0 if err.
  - rresp is identical on every beat. rlast = 1 on the final beat only.
  - On rvalid & rready the index advances; after the final beat the block returns to IDLE.
## Timing
- Reset values: all ready/valid outputs and rlast are 0; bresp, rresp, bid, rid and rdata are 0; state is IDLE; prio_w is 1. Memory contents are not reset.
- Reset mid-burst aborts immediately with no response. Writes already accepted remain in memory.
- AW/AR ready may depend combinationally on valid, and is asserted only in IDLE.
- First-beat latency:
  - wready rises the cycle after the AW handshake.
  - rvalid rises the cycle after the AR handshake.
  - bvalid rises the cycle after the last W handshake.
- Sustained throughput: one beat per cycle with no bubbles. valid is held until the handshake and the payload is stable while stalled.
## Test plan
- Write: awaddr = base + 0x10, len 3, data 0x11..0x44, wstrb 0xFF -> 4 beats accepted back-to-back, bresp 00, bid = awid.
- Read of the same address, len 3, rready toggling every cycle -> rdata 0x11, 0x22, 0x33, 0x44 in order, rlast on beat 4 only, payload stable while stalled.
- Partial strobes: word preloaded 0xFFFF_FFFF_FFFF_FFFF, then a single write of 0 with wstrb 0x0F -> read returns 0xFFFF_FFFF_0000_0000.
- awvalid and arvalid held together for 4 transactions -> grant order W, R, W, R.
- Error cases, each giving SLVERR:
  - araddr = base − 8 -> data 0.
  - awsize = 2 -> memory unchanged.
  - wlast asserted on beat 2 of 4 -> all 4 beats consumed, SLVERR.
- Wrap: awaddr = last word, len 1 -> beat 2 lands in word 0. Also assert aresetn mid read burst -> rvalid = 0 the same cycle, then IDLE.
